// File: rtl/baud_gen_frac_if.sv
`default_nettype none
// ============================================================================
// Module      : baud_gen_frac_if
// Description : Divisor configuration handshake between a host and the
//               fractional baud tick generator.
// Revision    : 1.0
// ============================================================================
interface baud_gen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_err;

    modport master (
        output cfg_valid, cfg_div_int, cfg_div_frac,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_div_int, cfg_div_frac,
        output cfg_ready, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module      : baud_gen_frac
// Description : UART tick generator with two fractional-N divider chains
//               (RX oversample ticks, TX bit ticks) and a runtime divisor.
// Revision    : 1.0
// ============================================================================
module baud_gen_frac #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  wire                            clk,
    input  wire                            reset,
    input  wire                            enable,
    baud_gen_frac_if.slave                 cfg,
    input  wire                            rx_resync,
    output logic                           rxclk_en,
    output logic [$clog2(OVERSAMPLE)-1:0]  rx_phase,
    output logic                           txclk_en
);

    localparam int                c_ph_w     = $clog2(OVERSAMPLE);
    localparam longint            c_def_d    = (longint'(CLK_HZ) << FRAC_W) /
                                               (longint'(BAUD) * longint'(OVERSAMPLE));
    localparam logic [DIV_W-1:0]  c_def_int  = DIV_W'(c_def_d >> FRAC_W);
    localparam logic [FRAC_W-1:0] c_def_frac = FRAC_W'(c_def_d);
    localparam logic [DIV_W-1:0]  c_min_int  = DIV_W'(2);

    generate
        if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_check
            $error("baud_gen_frac: OVERSAMPLE must be a power of two >= 4");
        end
    endgenerate

    // Active and pending divisor state
    logic [DIV_W-1:0]  r_div_int;
    logic [FRAC_W-1:0] r_div_frac;
    logic              r_pending;
    logic [DIV_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic              r_cfg_ready;
    logic              r_cfg_err;

    // Divider chains
    logic [DIV_W-1:0]  r_rx_cnt;
    logic [FRAC_W-1:0] r_rx_acc;
    logic [c_ph_w-1:0] r_rx_os;
    logic [DIV_W-1:0]  r_tx_cnt;
    logic [FRAC_W-1:0] r_tx_acc;
    logic [c_ph_w-1:0] r_tx_os;

    logic              w_accept;
    logic              w_clamp;
    logic              w_tx_sub;
    logic              w_tx_tick;
    logic              w_apply;
    logic              w_pending_nxt;
    logic [FRAC_W:0]   w_rx_sum;
    logic [FRAC_W:0]   w_tx_sum;
    logic [DIV_W-1:0]  w_rx_reload;
    logic [DIV_W-1:0]  w_tx_reload;
    logic [DIV_W-1:0]  w_resync_cnt;
    logic [DIV_W-1:0]  w_pend_cnt;

    assign w_accept      = cfg.cfg_valid && r_cfg_ready;
    assign w_clamp       = cfg.cfg_div_int < c_min_int;
    assign w_tx_sub      = (r_tx_cnt == '0);
    assign w_tx_tick     = w_tx_sub && (r_tx_os == '0);
    // Swap divisors only at a bit boundary so a TX bit never mixes two periods
    assign w_apply       = r_pending && (!enable || w_tx_tick);
    assign w_pending_nxt = w_accept ? 1'b1 : (w_apply ? 1'b0 : r_pending);

    assign w_rx_sum      = {1'b0, r_rx_acc} + {1'b0, r_div_frac};
    assign w_tx_sum      = {1'b0, r_tx_acc} + {1'b0, r_div_frac};
    assign w_rx_reload   = r_div_int - DIV_W'(1) + DIV_W'(w_rx_sum[FRAC_W]);
    assign w_tx_reload   = r_div_int - DIV_W'(1) + DIV_W'(w_tx_sum[FRAC_W]);
    assign w_resync_cnt  = (r_div_int >> 1) - DIV_W'(1);
    assign w_pend_cnt    = r_pend_int - DIV_W'(1);

    assign cfg.cfg_ready = r_cfg_ready;
    assign cfg.cfg_err   = r_cfg_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_int   <= c_def_int;
            r_div_frac  <= c_def_frac;
            r_pending   <= 1'b0;
            r_pend_int  <= c_def_int;
            r_pend_frac <= c_def_frac;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (w_apply) begin
                r_div_int  <= r_pend_int;
                r_div_frac <= r_pend_frac;
            end
            if (w_accept) begin
                r_pend_int  <= w_clamp ? c_min_int : cfg.cfg_div_int;
                r_pend_frac <= w_clamp ? '0 : cfg.cfg_div_frac;
                r_cfg_err   <= w_clamp;
            end
            r_pending   <= w_pending_nxt;
            r_cfg_ready <= !w_pending_nxt;
        end
    end

    // RX chain: apply beats resync, resync beats a coincident sub-tick
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_rx_cnt <= '0;
            r_rx_acc <= '0;
            r_rx_os  <= '0;
            rxclk_en <= 1'b0;
            rx_phase <= '0;
        end else if (w_apply) begin
            r_rx_cnt <= w_pend_cnt;
            r_rx_acc <= '0;
            r_rx_os  <= '0;
            rxclk_en <= 1'b0;
        end else if (rx_resync) begin
            r_rx_cnt <= w_resync_cnt;
            r_rx_acc <= '0;
            r_rx_os  <= '0;
            rxclk_en <= 1'b0;
        end else if (r_rx_cnt == '0) begin
            r_rx_cnt <= w_rx_reload;
            r_rx_acc <= w_rx_sum[FRAC_W-1:0];
            r_rx_os  <= r_rx_os + c_ph_w'(1);
            rxclk_en <= 1'b1;
            rx_phase <= r_rx_os;
        end else begin
            r_rx_cnt <= r_rx_cnt - DIV_W'(1);
            rxclk_en <= 1'b0;
        end
    end

    // TX chain: the apply edge still emits its tick, then reloads from the new divisor
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_tx_cnt <= '0;
            r_tx_acc <= '0;
            r_tx_os  <= '0;
            txclk_en <= 1'b0;
        end else if (w_tx_sub) begin
            r_tx_cnt <= w_apply ? w_pend_cnt : w_tx_reload;
            r_tx_acc <= w_apply ? '0 : w_tx_sum[FRAC_W-1:0];
            r_tx_os  <= r_tx_os + c_ph_w'(1);
            txclk_en <= (r_tx_os == '0);
        end else begin
            r_tx_cnt <= r_tx_cnt - DIV_W'(1);
            txclk_en <= 1'b0;
        end
    end

endmodule
`default_nettype wire
